sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares one SRAM-like bus between the instruction-fetch port and the data port driven by the `memory` stage (`mem_en`/`mem_wen`/`mem_addr`/`mem_wdata`/`mem_rdata`). Each requester gets a hold-until-done interface. The bus side uses a split address/data handshake with one transaction outstanding at a time. Sits between the pipeline and the bus bridge.

## Interface
- No parameters; widths fixed at 32-bit address/data, 4-bit byte strobe.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `inst_en` in 1: fetch request; held until `inst_done`.
- `inst_addr` in 32: fetch address.
- `inst_rdata` out 32: fetched word; valid with `inst_done`, held until next `inst_done`.
- `inst_done` out 1: one-cycle completion pulse.
- `data_en` in 1: data request (the memory stage `mem_en`).
- `data_wen` in 4: byte strobes; 0 means load.
- `data_addr` in 32: data address.
- `data_wdata` in 32: lane-replicated write data.
- `data_rdata` out 32: load word; valid with `data_done`, held until next `data_done`.
- `data_done` out 1: one-cycle completion pulse.
- `bus_req` out 1: bus request.
- `bus_wr` out 1: 1 = write; equals `|bus_wstrb`.
- `bus_wstrb` out 4: latched strobes.
- `bus_addr` out 32: latched address.
- `bus_wdata` out 32: latched write data.
- `bus_addr_ok` in 1: request accepted when sampled with `bus_req`.
- `bus_data_ok` in 1: response or write acknowledge. Never in the same cycle as the matching `bus_addr_ok`.
- `bus_rdata` in 32: read data, valid with `bus_data_ok`.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE: grant rules**
  - Eligible port: its `en` is high and its `done` is not asserted this cycle. The done-cycle mask prevents re-granting a request the requester has not yet dropped.
  - Both eligible: grant data, unless the previous grant was data. Then grant inst. This gives alternation under continuous contention, so neither port starves.
  - On grant: latch owner, addr, wen (0 for inst), and wdata into bus registers. Go to REQ.
  - No eligible port: stay in IDLE.
- **REQ**
  - `bus_req`=1; bus fields are driven from the latches only.
  - `bus_addr_ok`=1: go to WAIT.
  - Otherwise hold REQ; all fields stay stable.
- **WAIT**
  - `bus_req`=0.
  - `bus_data_ok`=1: register `bus_rdata` into the owner's rdata register, pulse the owner's `done` on the next cycle, go to IDLE.
  - For writes, rdata registers are not updated; `done` still pulses.
- **Ignored inputs and changes**
  - `bus_data_ok` is ignored in IDLE and REQ.
  - `bus_addr_ok` is ignored outside REQ.
  - Requester input changes after grant are ignored.
  - Dropping `en` after grant does not abort the transaction; `done` still pulses.
- `last_owner` updates only on grant.

## Timing
- Reset (`rst`=0 at an edge) gives state IDLE and the following:
  - `bus_req`=0, `bus_wr`=0, `bus_wstrb`=0, `bus_addr`=0, `bus_wdata`=0.
  - `inst_done`=0, `data_done`=0, `inst_rdata`=0, `data_rdata`=0.
  - `last_owner`=inst, so data wins the first contention.
- Reset mid-transaction abandons it with no `done` pulse. The bridge is reset alongside.
- Minimum latency, with `en` seen in IDLE at cycle 0:
  - cycle 1: REQ with `bus_addr_ok`.
  - cycle 2: WAIT with `bus_data_ok`.
  - cycle 3: `done` pulse with rdata valid.
- Each extra cycle of `bus_addr_ok`/`bus_data_ok` delay adds one cycle.
- Cycle 3 is IDLE; a new grant there issues `bus_req` at cycle 4. Best-case throughput is one transaction per 4 cycles.
- Every output is registered; no input-to-output combinational path.

## Structure
- Shared package `sirius_bus_pkg`:
  - `arb_state_t` enum {IDLE, REQ, WAIT}.
  - `arb_owner_t` enum {OWN_INST, OWN_DATA}.
  - `STRB_NONE` = 4'b0000.
- Single module, no sub-module. Grant logic is a small combinational function inside it.

## Test plan
- **Single data load.** After reset, `data_en`=1, `data_wen`=0, addr 0x0000_1004; bridge returns `addr_ok` on cycle 1 and `data_ok` with rdata 0xDEAD_BEEF on cycle 2. Expected: `bus_req` high on cycle 1 only, `data_done` pulse on cycle 3, `data_rdata`=0xDEAD_BEEF, `inst_done` stays 0.
- **Store, byte lane 2.** `data_wen`=4'b0100, wdata 0x5A5A_5A5A, addr 0x0000_2002. Expected: `bus_wr`=1, `bus_wstrb`=4'b0100, `data_done` pulses, `data_rdata` unchanged.
- **Contention.** `inst_en` and `data_en` both held continuously. Expected: grants alternate data, inst, data, inst; four `done` pulses in that order; no repeated grant during a done cycle.
- **Bus stall.** `bus_addr_ok` delayed 5 cycles, then `bus_data_ok` delayed 3 cycles; requester changes `data_addr` mid-transaction. Expected: `bus_req`/`bus_addr`/`bus_wdata` stable through the stall, `done` 10 cycles after grant, and the original address is used.
- **Reset mid-WAIT.** Assert `rst`=0 for one cycle while in WAIT, then pulse `bus_data_ok`. Expected: all outputs 0, no `done` pulse, state IDLE, next request served normally.

Source files
------------

// File: rtl/sirius_bus_pkg.sv
// Shared types for the sirius pipeline bus slice: arbiter states, bus owners
// and the "no byte lanes" strobe value that marks a load.
package sirius_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_INST,
    OWN_DATA
  } arb_owner_t;

  localparam logic [3:0] STRB_NONE = 4'b0000;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one split address/data
// SRAM-like bus, one outstanding transaction at a time, alternating under contention.
module sram_arbiter
  import sirius_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_done,

  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  arb_state_t  state_q, state_d;
  arb_owner_t  last_owner_q, last_owner_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_wr_q, bus_wr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        inst_done_q, inst_done_d;
  logic        data_done_q, data_done_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic        inst_elig;
  logic        data_elig;
  arb_owner_t  grant_owner;

  // Data wins a tie unless it held the previous grant, so contention alternates.
  function automatic arb_owner_t pick_owner(input logic inst_ok,
                                            input logic data_ok,
                                            input arb_owner_t last);
    if (data_ok && (!inst_ok || last != OWN_DATA)) begin
      return OWN_DATA;
    end
    return OWN_INST;
  endfunction

  // A port whose done pulse is showing has not had a chance to drop en yet.
  assign inst_elig   = inst_en && !inst_done_q;
  assign data_elig   = data_en && !data_done_q;
  assign grant_owner = pick_owner(inst_elig, data_elig, last_owner_q);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      IDLE: begin
        if (inst_elig || data_elig) begin
          state_d      = REQ;
          bus_req_d    = 1'b1;
          last_owner_d = grant_owner;
          if (grant_owner == OWN_DATA) begin
            bus_addr_d  = data_addr;
            bus_wstrb_d = data_wen;
            bus_wdata_d = data_wdata;
            bus_wr_d    = (data_wen != STRB_NONE);
          end else begin
            bus_addr_d  = inst_addr;
            bus_wstrb_d = STRB_NONE;
            bus_wdata_d = 32'h0;
            bus_wr_d    = 1'b0;
          end
        end
      end

      REQ: begin
        if (bus_addr_ok) begin
          state_d   = WAIT;
          bus_req_d = 1'b0;
        end
      end

      WAIT: begin
        // last_owner_q doubles as the owner of the transaction in flight.
        if (bus_data_ok) begin
          state_d = IDLE;
          if (last_owner_q == OWN_DATA) begin
            data_done_d = 1'b1;
            if (!bus_wr_q) begin
              data_rdata_d = bus_rdata;
            end
          end else begin
            inst_done_d  = 1'b1;
            inst_rdata_d = bus_rdata;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_INST;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_wstrb_q  <= STRB_NONE;
      bus_addr_q   <= 32'h0;
      bus_wdata_q  <= 32'h0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_wr     = bus_wr_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign inst_done  = inst_done_q;
  assign data_done  = data_done_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: drives inputs and samples outputs on the
// falling edge, acting as both requesters and the bus bridge.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int checks;
  int errors;

  sram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .inst_en    (inst_en),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_done  (inst_done),
    .data_en    (data_en),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_done  (data_done),
    .bus_req    (bus_req),
    .bus_wr     (bus_wr),
    .bus_wstrb  (bus_wstrb),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok),
    .bus_rdata  (bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    inst_en = 1'b0; inst_addr = 32'h0;
    data_en = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    tick();
    tick();
    checks++;
    if ({bus_req, bus_wr, bus_wstrb} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_bus_ctrl: req=%0b wr=%0b wstrb=%h, wanted all 0", bus_req, bus_wr, bus_wstrb);
    end
    checks++;
    if ({bus_addr, bus_wdata} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_bus_data: addr=%h wdata=%h, wanted 0", bus_addr, bus_wdata);
    end
    checks++;
    if ({inst_done, data_done} !== 2'b0 || {inst_rdata, data_rdata} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_req_side: idone=%0b ddone=%0b irdata=%h drdata=%h, wanted 0",
               inst_done, data_done, inst_rdata, data_rdata);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load();
    data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_1004; data_wdata = 32'h0;
    tick();
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h0000_1004 || bus_wr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_req: req=%0b addr=%h wr=%0b, wanted 1/00001004/0", bus_req, bus_addr, bus_wr);
    end
    bus_addr_ok = 1'b1;
    tick();
    checks++;
    if (bus_req !== 1'b0 || data_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_wait: req=%0b done=%0b, wanted 0/0", bus_req, data_done);
    end
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (data_done !== 1'b1 || data_rdata !== 32'hDEAD_BEEF || inst_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_done: ddone=%0b rdata=%h idone=%0b, wanted 1/deadbeef/0",
               data_done, data_rdata, inst_done);
    end
    // data_en held across the done cycle must not be granted again
    bus_data_ok = 1'b0; bus_rdata = 32'h0;
    tick();
    checks++;
    if (data_done !== 1'b0 || bus_req !== 1'b0 || data_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL load_mask: ddone=%0b req=%0b rdata=%h, wanted 0/0/deadbeef",
               data_done, bus_req, data_rdata);
    end
    data_en = 1'b0;
    tick();
  endtask

  task automatic test_store();
    data_en = 1'b1; data_wen = 4'b0100; data_addr = 32'h0000_2002; data_wdata = 32'h5A5A_5A5A;
    tick();
    checks++;
    if (bus_req !== 1'b1 || bus_wr !== 1'b1 || bus_wstrb !== 4'b0100 ||
        bus_addr !== 32'h0000_2002 || bus_wdata !== 32'h5A5A_5A5A) begin
      errors++;
      $display("[TB] FAIL store_req: req=%0b wr=%0b wstrb=%b addr=%h wdata=%h, wanted 1/1/0100/00002002/5a5a5a5a",
               bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata);
    end
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    checks++;
    if (data_done !== 1'b1 || data_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL store_done: ddone=%0b rdata=%h, wanted 1/deadbeef", data_done, data_rdata);
    end
    bus_data_ok = 1'b0; bus_rdata = 32'h0; data_en = 1'b0; data_wen = 4'h0;
    tick();
    checks++;
    if (data_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL store_pulse: ddone=%0b, wanted 0", data_done);
    end
  endtask

  task automatic test_contention();
    logic [31:0] exp_addr;
    logic        exp_data;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    inst_en = 1'b1; inst_addr = 32'h0000_0100;
    data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      exp_data = (i % 2 == 0);
      exp_addr = exp_data ? 32'h0000_0200 : 32'h0000_0100;
      tick();
      checks++;
      if (bus_req !== 1'b1 || bus_addr !== exp_addr) begin
        errors++;
        $display("[TB] FAIL contention_grant%0d: req=%0b addr=%h, wanted 1/%h", i, bus_req, bus_addr, exp_addr);
      end
      bus_addr_ok = 1'b1;
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hA000_0000 + 32'(i);
      tick();
      checks++;
      if (data_done !== exp_data || inst_done !== !exp_data ||
          (exp_data ? data_rdata : inst_rdata) !== 32'hA000_0000 + 32'(i)) begin
        errors++;
        $display("[TB] FAIL contention_done%0d: ddone=%0b idone=%0b drdata=%h irdata=%h, wanted data=%0b rdata=%h",
                 i, data_done, inst_done, data_rdata, inst_rdata, exp_data, 32'hA000_0000 + 32'(i));
      end
      bus_data_ok = 1'b0; bus_rdata = 32'h0;
    end
    inst_en = 1'b0; data_en = 1'b0;
    tick();
    checks++;
    if (bus_req !== 1'b0 || inst_done !== 1'b0 || data_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL contention_idle: req=%0b idone=%0b ddone=%0b, wanted 0/0/0", bus_req, inst_done, data_done);
    end
  endtask

  task automatic test_bus_stall();
    data_en = 1'b1; data_wen = 4'b1111; data_addr = 32'h0000_3000; data_wdata = 32'hCAFE_F00D;
    for (int t = 0; t <= 10; t++) begin
      tick();
      if (t <= 5) begin
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0000_3000 || bus_wdata !== 32'hCAFE_F00D) begin
          errors++;
          $display("[TB] FAIL stall_hold%0d: req=%0b addr=%h wdata=%h, wanted 1/00003000/cafef00d",
                   t, bus_req, bus_addr, bus_wdata);
        end
      end else if (t <= 9) begin
        checks++;
        if (bus_req !== 1'b0 || data_done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall_wait%0d: req=%0b ddone=%0b, wanted 0/0", t, bus_req, data_done);
        end
      end else begin
        checks++;
        if (data_done !== 1'b1 || data_rdata !== 32'hA000_0002) begin
          errors++;
          $display("[TB] FAIL stall_done: ddone=%0b rdata=%h, wanted 1/a0000002", data_done, data_rdata);
        end
      end
      if (t == 2) begin
        data_addr = 32'hFFFF_FFF0; data_wdata = 32'h0BAD_0BAD;
      end
      // stray data_ok while in REQ and addr_ok while in WAIT must both be ignored
      bus_addr_ok = (t == 5) || (t == 7);
      bus_data_ok = (t == 1) || (t == 9);
      bus_rdata   = (t == 9) ? 32'h7777_7777 : 32'h0;
    end
    data_en = 1'b0; data_wen = 4'h0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_4000;
    tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if ({bus_req, bus_wr, bus_wstrb, inst_done, data_done} !== 8'b0 ||
        {bus_addr, bus_wdata, inst_rdata, data_rdata} !== 128'h0) begin
      errors++;
      $display("[TB] FAIL rstwait_outputs: req=%0b addr=%h ddone=%0b drdata=%h irdata=%h, wanted all 0",
               bus_req, bus_addr, data_done, data_rdata, inst_rdata);
    end
    rst = 1'b1; data_en = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'h9999_9999;
    tick();
    checks++;
    if (data_done !== 1'b0 || inst_done !== 1'b0 || bus_req !== 1'b0 || data_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rstwait_nodone: ddone=%0b idone=%0b req=%0b drdata=%h, wanted 0/0/0/0",
               data_done, inst_done, bus_req, data_rdata);
    end
    bus_data_ok = 1'b0; bus_rdata = 32'h0;
    inst_en = 1'b1; inst_addr = 32'h0000_0500;
    tick();
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0500 || bus_wr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstwait_newreq: req=%0b addr=%h wr=%0b, wanted 1/00000500/0", bus_req, bus_addr, bus_wr);
    end
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h600D_F00D;
    tick();
    checks++;
    if (inst_done !== 1'b1 || inst_rdata !== 32'h600D_F00D || data_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstwait_newdone: idone=%0b irdata=%h ddone=%0b, wanted 1/600df00d/0",
               inst_done, inst_rdata, data_done);
    end
    bus_data_ok = 1'b0; bus_rdata = 32'h0; inst_en = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load();
    test_store();
    test_contention();
    test_bus_stall();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
